// File: rtl/odd_sort.sv
// rtl/odd_sort.sv - in-place ascending signed bubble sort of N RAM words over a single-port RAM
// Optional macro ODD_SORT_EARLY_EXIT_EN: finish after the first pass that performs no swap.
module odd_sort #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [$clog2(DEPTH):0]     i_count,
    output logic                       o_rden,
    output logic                       o_wren,
    output logic [$clog2(DEPTH)-1:0]   o_addr,
    output logic signed [WIDTH-1:0]    o_wdata,
    input  logic signed [WIDTH-1:0]    i_rdata,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [$clog2(DEPTH)-1:0]   o_pass_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_A,
        S_LD_A,
        S_RD_B,
        S_LD_B,
        S_CMP,
        S_WR_A,
        S_WR_B,
        S_ADV,
        S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_next;

    logic [CW-1:0]             r_n;
    logic [CW-1:0]             r_p;
    logic [CW-1:0]             r_j;
    logic signed [WIDTH-1:0]   r_a;
    logic signed [WIDTH-1:0]   r_b;

    logic                      w_accept;
    logic [CW-1:0]             w_n_cap;
    logic [CW-1:0]             w_lim;
    logic [CW-1:0]             w_j1;
    logic                      w_more;
    logic                      w_last_pass;
    logic                      w_end_sort;

    assign w_accept    = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_n_cap     = (i_count > CW'(DEPTH)) ? CW'(DEPTH) : i_count;
    // Extra top bit keeps n-1-p and j+1 exact when n equals DEPTH.
    assign w_lim       = r_n - CW'(1) - r_p;
    assign w_j1        = r_j + CW'(1);
    assign w_more      = w_j1 < w_lim;
    assign w_last_pass = (r_p + CW'(1)) == (r_n - CW'(1));

`ifdef ODD_SORT_EARLY_EXIT_EN
    logic                      r_swap;

    assign w_end_sort  = w_last_pass || !r_swap;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_swap <= 1'b0;
        end else if (r_state == S_RD_A) begin
            r_swap <= 1'b0;
        end else if (r_state == S_WR_A) begin
            r_swap <= 1'b1;
        end
    end
`else
    assign w_end_sort  = w_last_pass;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_n <= '0;
            r_p <= '0;
            r_j <= '0;
            r_a <= '0;
            r_b <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_n <= w_n_cap;
                        r_p <= '0;
                        r_j <= '0;
                    end
                end
                S_LD_A: r_a <= i_rdata;
                S_LD_B: r_b <= i_rdata;
                S_CMP: begin
                    // No swap: the larger (or equal) right value carries forward.
                    if (!(r_a > r_b)) begin
                        r_a <= r_b;
                    end
                end
                S_ADV: begin
                    if (w_more) begin
                        r_j <= w_j1;
                    end else begin
                        r_p <= r_p + CW'(1);
                        r_j <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_next = (w_n_cap < CW'(2)) ? S_DONE : S_RD_A;
                end
            end
            S_RD_A: w_next = S_LD_A;
            S_LD_A: w_next = S_RD_B;
            S_RD_B: w_next = S_LD_B;
            S_LD_B: w_next = S_CMP;
            S_CMP:  w_next = (r_a > r_b) ? S_WR_A : S_ADV;
            S_WR_A: w_next = S_WR_B;
            S_WR_B: w_next = S_ADV;
            S_ADV: begin
                if (w_more) begin
                    w_next = S_RD_B;
                end else if (w_end_sort) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_RD_A;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_rden  = 1'b0;
        o_wren  = 1'b0;
        o_addr  = '0;
        o_wdata = '0;
        case (r_state)
            S_RD_A: o_rden = 1'b1;
            S_RD_B: begin
                o_rden = 1'b1;
                o_addr = w_j1[AW-1:0];
            end
            S_WR_A: begin
                o_wren  = 1'b1;
                o_addr  = r_j[AW-1:0];
                o_wdata = r_b;
            end
            S_WR_B: begin
                o_wren  = 1'b1;
                o_addr  = w_j1[AW-1:0];
                o_wdata = r_a;
            end
            default: ;
        endcase
    end

    assign o_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done     = (r_state == S_DONE);
    assign o_pass_cnt = r_p[AW-1:0];

endmodule

// File: tb/tb_odd_sort.sv
// tb/tb_odd_sort.sv - self-checking bench for odd_sort against an array-level bubble sort reference
module tb_odd_sort;

    localparam int DEPTH = 32;
    localparam int WIDTH = 8;
    localparam int AW    = 5;
    localparam int LIMIT = 20000;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [AW:0]              count;
    logic                     rden;
    logic                     wren;
    logic [AW-1:0]            addr;
    logic signed [WIDTH-1:0]  wdata;
    logic signed [WIDTH-1:0]  rdata;
    logic                     busy;
    logic                     done;
    logic [AW-1:0]            pass_cnt;

    logic signed [WIDTH-1:0]  mem [DEPTH];
    logic                     ld_en;
    logic [AW-1:0]            ld_addr;
    logic signed [WIDTH-1:0]  ld_data;

    int wr_cnt = 0, rd_cnt = 0, oob_cnt = 0, both_cnt = 0, stray_cnt = 0;
    int addr_lim;
    int n_chk = 0, n_pass = 0;
    int src [DEPTH];
    int exp_arr [DEPTH];
    int last_wr, last_cmps;

    always #5 clk = ~clk;

    odd_sort #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_count    (count),
        .o_rden     (rden),
        .o_wren     (wren),
        .o_addr     (addr),
        .o_wdata    (wdata),
        .i_rdata    (rdata),
        .o_busy     (busy),
        .o_done     (done),
        .o_pass_cnt (pass_cnt)
    );

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (wren) mem[addr] <= wdata;
        if (rden) rdata <= mem[addr];
    end

    always @(negedge clk) begin
        if (wren) wr_cnt <= wr_cnt + 1;
        if (rden) rd_cnt <= rd_cnt + 1;
        if ((rden || wren) && int'(addr) > addr_lim) oob_cnt <= oob_cnt + 1;
        if (rden && wren) both_cnt <= both_cnt + 1;
        if (!rden && !wren && (addr != '0 || wdata != '0)) stray_cnt <= stray_cnt + 1;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    // Reference: plain array bubble sort, reporting passes, compares and swaps.
    task automatic model(input int n, output int passes, output int cmps, output int swaps);
        int t;
        bit sw;
        passes = 0; cmps = 0; swaps = 0;
        if (n >= 2) begin
            for (int p = 0; p < n - 1; p++) begin
                sw = 0;
                for (int j = 0; j < n - 1 - p; j++) begin
                    cmps++;
                    if (exp_arr[j] > exp_arr[j+1]) begin
                        t = exp_arr[j]; exp_arr[j] = exp_arr[j+1]; exp_arr[j+1] = t;
                        swaps++;
                        sw = 1;
                    end
                end
                passes++;
`ifdef ODD_SORT_EARLY_EXIT_EN
                if (!sw) break;
`endif
            end
        end
    endtask

    task automatic load_ram(input int n);
        for (int i = 0; i < n; i++) begin
            ld_en = 1'b1; ld_addr = AW'(i); ld_data = WIDTH'(src[i]);
            @(posedge clk); #1;
        end
        ld_en = 1'b0;
    endtask

    task automatic run_sort(input string tag, input int cnt, input bit inject);
        int n_eff, passes, cmps, swaps, cyc, busyc, wr0, rd0, oob0, both0, stray0;
        n_eff = (cnt > DEPTH) ? DEPTH : cnt;
        for (int i = 0; i < DEPTH; i++) exp_arr[i] = int'(mem[i]);
        model(n_eff, passes, cmps, swaps);
        addr_lim = n_eff - 1;
        wr0 = wr_cnt; rd0 = rd_cnt; oob0 = oob_cnt; both0 = both_cnt; stray0 = stray_cnt;
        count = (AW+1)'(cnt); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; busyc = 0;
        while (!done && cyc < LIMIT) begin
            if (busy) busyc++;
            start = inject && (cyc == 3 || cyc == 7);
            if (start) count = (AW+1)'(0);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({tag, " timeout"}, cyc < LIMIT, 1);
        chk({tag, " done"}, done, 1);
        chk({tag, " cycles"}, cyc, passes * 2 + cmps * 4 + swaps * 2);
        chk({tag, " busy_cycles"}, busyc, cyc);
        chk({tag, " pass_cnt"}, pass_cnt, passes);
        chk({tag, " writes"}, wr_cnt - wr0, 2 * swaps);
        chk({tag, " reads"}, rd_cnt - rd0, passes + cmps);
        chk({tag, " addr_range"}, oob_cnt - oob0, 0);
        chk({tag, " rd_wr_both"}, both_cnt - both0, 0);
        chk({tag, " idle_bus"}, stray_cnt - stray0, 0);
        for (int i = 0; i < DEPTH; i++)
            chk($sformatf("%s ram[%0d]", tag, i), $signed(mem[i]), exp_arr[i]);
        last_wr = wr_cnt - wr0;
        last_cmps = cmps;
    endtask

    initial begin
        int cyc, ws, w0, n_r;
        rst = 1'b1; start = 1'b0; count = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; addr_lim = -1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst rden", rden, 0);
        chk("rst wren", wren, 0);
        chk("rst addr", addr, 0);
        chk("rst wdata", wdata, 0);
        chk("rst pass_cnt", pass_cnt, 0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) src[i] = 0;
        load_ram(DEPTH);

        src[0] = 9; src[1] = -3; src[2] = 7; src[3] = 1;
        load_ram(4);
        run_sort("mix4", 4, 0);

        src[0] = -7; src[1] = -1; src[2] = 3; src[3] = 5; src[4] = 9;
        load_ram(5);
        run_sort("sorted5", 5, 0);
        chk("sorted5 no_wren", last_wr, 0);

        run_sort("n0", 0, 0);
        run_sort("n1", 1, 0);

        for (int i = 0; i < DEPTH; i++) src[i] = 63 - 2 * i;
        load_ram(DEPTH);
        run_sort("desc32", 32, 0);
        chk("desc32 all_swap", last_wr, 2 * last_cmps);

        src[0] = 8; src[1] = 6; src[2] = 4; src[3] = 2;
        load_ram(4);
        addr_lim = 3;
        count = (AW+1)'(4); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; ws = 0;
        while (cyc < 1000) begin
            if (wren) begin
                ws++;
                if (ws == 5) break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort third_wr_a", ws, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort rden", rden, 0);
        chk("abort wren", wren, 0);
        chk("abort addr", addr, 0);
        chk("abort wdata", wdata, 0);
        chk("abort pass_cnt", pass_cnt, 0);
        w0 = wr_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("abort no_writes", wr_cnt - w0, 0);
        chk("abort still_idle", busy, 0);
        run_sort("restart4", 4, 0);

        src[0] = 3; src[1] = 3; src[2] = -5;
        load_ram(3);
        run_sort("dup3", 3, 1);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < DEPTH; i++) src[i] = int'($signed(WIDTH'($urandom)));
            load_ram(DEPTH);
            n_r = (r == 0) ? 40 : int'($urandom_range(0, 33));
            run_sort($sformatf("rand%0d", r), n_r, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
